multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath. It replaces one-shot opcode decoding with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the PC, IR, memory, ALU-mux and register-file enables cycle by cycle, and stalls on a shared instruction/data memory ready handshake. Supported opcodes: R-type, lw, sw, beq, addi, andi, j; any other opcode traps.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- opcode  in  6  instr[31:26] from the IR; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data select: 1 = MDR
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU operand B: 00 = rt, 01 = 4, 10 = immediate, 11 = immediate<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = and
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- zext_imm  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- trap  out  1  illegal opcode seen; sticky until reset
- state  out  4  current state encoding, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
- Outputs are a combinational decode of `state` (and `mem_ready` where stated). Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are 1 only when mem_ready=1.
  - Moves to DECODE on mem_ready; otherwise stays in FETCH.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Captures opcode into an internal op_q register.
  - Next state by opcode: 000000 → R_EXEC; 100011 or 101011 → MEM_ADDR; 000100 → BRANCH; 000010 → JUMP; 001000 or 001100 → I_EXEC; anything else → TRAP.
- MEM_ADDR: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ if op_q = lw, otherwise MEM_WRITE.
- MEM_READ: drives MemRead=1, IorD=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: drives RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to FETCH.
- MEM_WRITE: drives MemWrite=1, IorD=1. Holds until mem_ready; on that cycle instr_done=1 and the next state is FETCH.
- R_EXEC: drives ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: drives RegWrite=1, RegDst=1, instr_done=1. Goes to FETCH.
- BRANCH: drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
- JUMP: drives PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- I_EXEC: drives ALUSrcA=1, ALUSrcB=10.
  - addi: ALUOp=00, zext_imm=0.
  - andi: ALUOp=11, zext_imm=1.
  - Goes to I_WB.
- I_WB: drives RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. zext_imm holds its I_EXEC value. Goes to FETCH.
- TRAP: trap=1, all enables 0. Stays in TRAP until reset.
- Rules that apply in every state:
  - MemRead and MemWrite are never both 1.
  - RegWrite never coincides with PCWrite.
  - Opcode changes after DECODE have no effect, because later states use op_q.

## Timing
- Reset:
  - rst_n=0 sampled at a rising edge → state=FETCH and op_q=0 at the next edge.
  - While rst_n=0, every output is forced to 0 (state reads 0).
  - Reset asserted mid-instruction abandons that instruction with no further writes after the reset edge.
- Latency with mem_ready held at 1:
  - lw 5 cycles.
  - sw, R-type, addi, andi 4 cycles.
  - beq, j 3 cycles.
- Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored in every other state.
- instr_done rises in the last cycle of the instruction. The next cycle is always FETCH, except after TRAP, which has no instr_done.

## Test plan
- Reset then R-type: hold rst_n=0 for 2 cycles and check all outputs are 0. Release, mem_ready=1, opcode=000000 → state 0,1,6,7,0; R_WB shows RegWrite=1, RegDst=1; instr_done high only in cycle 4.
- lw with stalls: opcode=100011, mem_ready=0 for 2 cycles in FETCH and 1 cycle in MEM_READ → 8 cycles total. IRWrite/PCWrite pulse once, in the mem_ready cycle. MEM_WB shows MemtoReg=1, RegWrite=1.
- sw then beq back-to-back, mem_ready=1 → sw takes 4 cycles with MemWrite=1, IorD=1 in cycle 4. beq then takes 3 cycles with PCWriteCond=1, ALUOp=01, PCSource=01.
- andi vs addi: opcode=001100 → I_EXEC shows ALUOp=11, zext_imm=1. opcode=001000 → ALUOp=00, zext_imm=0. Change opcode to 000000 during I_EXEC → outputs unchanged.
- j: opcode=000010 → JUMP cycle shows PCWrite=1, PCSource=10; back in FETCH 3 cycles after the first FETCH.
- Illegal opcode 111111: enters TRAP at cycle 3; trap=1 and all enables 0 for 10+ cycles. rst_n=0 for one edge → FETCH with trap=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller.
// Moore FSM that walks each instruction through fetch, decode, execute,
// memory and write-back, stalling on the shared memory ready handshake.
// Outputs are a combinational decode of the current state (plus mem_ready
// in the memory-wait states) and are all held at 0 while rst_n is low.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       zext_imm,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op_q;

    // State register and opcode capture; op_q freezes the opcode at DECODE
    // so later IR changes cannot redirect the instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state selection; only the three memory states wait on mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_d = S_R_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI,
                    OP_ANDI:        state_d = S_I_EXEC;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Control decode; everything is quiet during reset and in unlisted states.
    always_comb begin
        // NOTE: every output is defaulted up front so no path through the
        // case statement can leave a latch behind.
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        zext_imm    = 1'b0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    ALUOp    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
                    zext_imm = (op_q == OP_ANDI);
                end
                S_I_WB: begin
                    RegWrite   = 1'b1;
                    zext_imm   = (op_q == OP_ANDI);
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = rst_n ? state_q : S_FETCH;

endmodule
